// File: rtl/qmr_pkg.sv
// Shared definitions for the QMR fault monitor.
// Holds the ALU count, vote field geometry, the majority agreement threshold,
// the health state encoding, readout select codes and a small popcount helper.
package qmr_pkg;

    localparam int unsigned N_ALU         = 5;
    localparam int unsigned VOTE_W        = 3;
    localparam int unsigned MAJ_MIN_AGREE = 2;

    typedef enum logic [1:0] {
        H_OK       = 2'b00,
        H_DEGRADED = 2'b01,
        H_CRITICAL = 2'b10
    } health_t;

    localparam logic [2:0] RD_FAULT0 = 3'd0;
    localparam logic [2:0] RD_FAULT1 = 3'd1;
    localparam logic [2:0] RD_FAULT2 = 3'd2;
    localparam logic [2:0] RD_FAULT3 = 3'd3;
    localparam logic [2:0] RD_FAULT4 = 3'd4;
    localparam logic [2:0] RD_NOMAJ  = 3'd5;
    localparam logic [2:0] RD_TOTAL  = 3'd6;
    localparam logic [2:0] RD_STATUS = 3'd7;

    function automatic logic [2:0] popcount5(input logic [N_ALU-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < int'(N_ALU); i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/qmr_alu_fault_track.sv
// Per-ALU fault tracker.
// Counts disagreements of one ALU with the voted majority (saturating), tracks
// the run of consecutive disagreements and latches a sticky failure bit once
// that run reaches PERSIST_TH.
// Ports:
//   clk, reset_n   clock / async active-low reset
//   clear_i        synchronous clear, beats a simultaneous sample
//   sample_i       valid execute cycle with a majority present
//   vote_i         number of other ALUs agreeing with this one
//   fault_cnt_o    saturating disagreement count
//   fail_o         registered sticky failure flag
//   fail_d_o       next-state failure flag (feeds the health FSM)
module qmr_alu_fault_track
    import qmr_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERSIST_TH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              sample_i,
    input  logic [VOTE_W-1:0] vote_i,
    output logic [CNT_W-1:0]  fault_cnt_o,
    output logic              fail_o,
    output logic              fail_d_o
);

    localparam logic [3:0] ConsecMax = 4'(PERSIST_TH);

    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic             fail_q, fail_d;
    logic             err;

    assign err = (vote_i < VOTE_W'(MAJ_MIN_AGREE));

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        consec_d    = consec_q;
        fail_d      = fail_q;
        if (clear_i) begin
            fault_cnt_d = '0;
            consec_d    = '0;
            fail_d      = 1'b0;
        end else if (sample_i) begin
            if (err) begin
                if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
                if (consec_q < ConsecMax) consec_d = consec_q + 4'd1;
                if (consec_d == ConsecMax) fail_d = 1'b1;
            end else begin
                consec_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_cnt_q <= '0;
            consec_q    <= '0;
            fail_q      <= 1'b0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
            consec_q    <= consec_d;
            fail_q      <= fail_d;
        end
    end

    assign fault_cnt_o = fault_cnt_q;
    assign fail_o      = fail_q;
    assign fail_d_o    = fail_d;

endmodule

// File: rtl/qmr_fault_monitor.sv
// QMR fault monitor, downstream of the 5-ALU execute-stage voter.
// Tracks per-ALU disagreement counts and persistent failures, counts
// no-majority and total valid samples, runs the OK/DEGRADED/CRITICAL health
// FSM and issues a one-cycle interrupt on new failures or entry to CRITICAL.
// Ports:
//   clk, reset_n        clock / async active-low reset
//   ex_valid_i          real ALU operation this cycle
//   vote_count_i        5 x 3-bit agreement counts, field i for ALU i+1
//   majority_status_i   voter winner 1..5, anything else = no majority
//   clear_i             synchronous clear of all state
//   rd_sel_i            readout select
//   rd_data_o           readout data
//   fail_mask_o         sticky per-ALU failure flags
//   health_o            00 OK, 01 DEGRADED, 10 CRITICAL
//   irq_o               one-cycle interrupt pulse
module qmr_fault_monitor
    import qmr_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERSIST_TH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ex_valid_i,
    input  logic [N_ALU*VOTE_W-1:0] vote_count_i,
    input  logic [2:0]              majority_status_i,
    input  logic                    clear_i,
    input  logic [2:0]              rd_sel_i,
    output logic [31:0]             rd_data_o,
    output logic [N_ALU-1:0]        fail_mask_o,
    output logic [1:0]              health_o,
    output logic                    irq_o
);

    logic             majority;
    logic             maj_sample;
    logic             nomaj_sample;
    logic [CNT_W-1:0] fault_cnt [N_ALU];
    logic [N_ALU-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] nomaj_cnt_q, nomaj_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    health_t          health_q, health_d;
    logic             irq_q, irq_d;
    logic [2:0]       fail_pop;

    // 6 and 7 are not ALU indices, so they count as no majority.
    assign majority     = (majority_status_i >= 3'd1) && (majority_status_i <= 3'd5);
    assign maj_sample   = ex_valid_i && majority;
    assign nomaj_sample = ex_valid_i && !majority;

    for (genvar g = 0; g < int'(N_ALU); g++) begin : g_alu
        qmr_alu_fault_track #(
            .CNT_W      (CNT_W),
            .PERSIST_TH (PERSIST_TH)
        ) u_track (
            .clk         (clk),
            .reset_n     (reset_n),
            .clear_i     (clear_i),
            .sample_i    (maj_sample),
            .vote_i      (vote_count_i[VOTE_W*g +: VOTE_W]),
            .fault_cnt_o (fault_cnt[g]),
            .fail_o      (fail_q[g]),
            .fail_d_o    (fail_d[g])
        );
    end

    assign fail_pop = popcount5(fail_d);

    always_comb begin
        nomaj_cnt_d = nomaj_cnt_q;
        total_cnt_d = total_cnt_q;
        health_d    = health_q;
        irq_d       = 1'b0;
        if (clear_i) begin
            nomaj_cnt_d = '0;
            total_cnt_d = '0;
            health_d    = H_OK;
        end else begin
            if (ex_valid_i && total_cnt_q != '1) total_cnt_d = total_cnt_q + 1'b1;
            if (nomaj_sample && nomaj_cnt_q != '1) nomaj_cnt_d = nomaj_cnt_q + 1'b1;

            // Health only ever worsens; CRITICAL and DEGRADED are left via clear.
            if (health_q != H_CRITICAL) begin
                if (nomaj_sample || fail_pop >= 3'd3) begin
                    health_d = H_CRITICAL;
                end else if (fail_pop != 3'd0) begin
                    health_d = H_DEGRADED;
                end
            end

            irq_d = (|(fail_d & ~fail_q)) ||
                    (health_d == H_CRITICAL && health_q != H_CRITICAL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nomaj_cnt_q <= '0;
            total_cnt_q <= '0;
            health_q    <= H_OK;
            irq_q       <= 1'b0;
        end else begin
            nomaj_cnt_q <= nomaj_cnt_d;
            total_cnt_q <= total_cnt_d;
            health_q    <= health_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_sel_i)
            RD_FAULT0: rd_data_o = 32'(fault_cnt[0]);
            RD_FAULT1: rd_data_o = 32'(fault_cnt[1]);
            RD_FAULT2: rd_data_o = 32'(fault_cnt[2]);
            RD_FAULT3: rd_data_o = 32'(fault_cnt[3]);
            RD_FAULT4: rd_data_o = 32'(fault_cnt[4]);
            RD_NOMAJ:  rd_data_o = 32'(nomaj_cnt_q);
            RD_TOTAL:  rd_data_o = 32'(total_cnt_q);
            RD_STATUS: rd_data_o = {22'b0, health_q, 3'b0, fail_q};
            default:   rd_data_o = '0;
        endcase
    end

    assign fail_mask_o = fail_q;
    assign health_o    = health_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_qmr_fault_monitor.sv
// Self-checking bench for qmr_fault_monitor: a vector table plus hand-written
// sequences drive a scoreboard queue that is compared one cycle after each
// sample. A second, narrow-counter instance exercises saturation cheaply.
module tb_qmr_fault_monitor;

    typedef struct {
        int          id;
        logic        valid;
        logic [14:0] votes;
        logic [2:0]  maj;
        logic        clr;
        logic [2:0]  rd_sel;
        logic [31:0] exp_rd;
        logic [4:0]  exp_mask;
        logic [1:0]  exp_health;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [14:0] vote_count;
    logic [2:0]  maj;
    logic        clear;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic [4:0]  fail_mask;
    logic [1:0]  health;
    logic        irq;

    logic        ex_valid2;
    logic [14:0] vote_count2;
    logic [2:0]  maj2;
    logic        clear2;
    logic [2:0]  rd_sel2;
    logic [31:0] rd_data2;
    logic [4:0]  fail_mask2;
    logic [1:0]  health2;
    logic        irq2;

    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;
    vec_t pend[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    qmr_fault_monitor u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ex_valid_i        (ex_valid),
        .vote_count_i      (vote_count),
        .majority_status_i (maj),
        .clear_i           (clear),
        .rd_sel_i          (rd_sel),
        .rd_data_o         (rd_data),
        .fail_mask_o       (fail_mask),
        .health_o          (health),
        .irq_o             (irq)
    );

    qmr_fault_monitor #(
        .CNT_W      (3),
        .PERSIST_TH (2)
    ) u_dut_small (
        .clk               (clk),
        .reset_n           (reset_n),
        .ex_valid_i        (ex_valid2),
        .vote_count_i      (vote_count2),
        .majority_status_i (maj2),
        .clear_i           (clear2),
        .rd_sel_i          (rd_sel2),
        .rd_data_o         (rd_data2),
        .fail_mask_o       (fail_mask2),
        .health_o          (health2),
        .irq_o             (irq2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Erring ALUs get errv, the rest okv.
    function automatic logic [14:0] mk_votes(input logic [4:0] err, input logic [2:0] errv,
                                             input logic [2:0] okv);
        logic [14:0] v;
        for (int i = 0; i < 5; i++) v[3*i +: 3] = err[i] ? errv : okv;
        return v;
    endfunction

    function automatic vec_t mk(input logic valid, input logic [14:0] votes,
                                input logic [2:0] m, input logic clr, input logic [2:0] rs,
                                input logic [31:0] erd, input logic [4:0] em,
                                input logic [1:0] eh, input logic ei);
        vec_t v;
        v.id = 0;
        v.valid = valid; v.votes = votes; v.maj = m; v.clr = clr; v.rd_sel = rs;
        v.exp_rd = erd; v.exp_mask = em; v.exp_health = eh; v.exp_irq = ei;
        return v;
    endfunction

    task automatic step(input vec_t v);
        @(posedge clk);
        #2;
        v.id       = vec_id;
        vec_id++;
        ex_valid   = v.valid;
        vote_count = v.votes;
        maj        = v.maj;
        clear      = v.clr;
        rd_sel     = v.rd_sel;
        pend.push_back(v);
    endtask

    task automatic idle(input logic [2:0] rs, input logic [31:0] erd, input logic [4:0] em,
                        input logic [1:0] eh);
        step(mk(1'b0, '0, 3'd0, 1'b0, rs, erd, em, eh, 1'b0));
    endtask

    // Scoreboard: outputs one cycle after each driven vector.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (pend.size() != 0) begin
                e = pend.pop_front();
                check($sformatf("vec%0d.mask", e.id), 32'(fail_mask), 32'(e.exp_mask));
                check($sformatf("vec%0d.health", e.id), 32'(health), 32'(e.exp_health));
                check($sformatf("vec%0d.irq", e.id), 32'(irq), 32'(e.exp_irq));
                check($sformatf("vec%0d.rd%0d", e.id, e.rd_sel), rd_data, e.exp_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] all4;
        logic [14:0] err3, err2, err1;
        logic [4:0]  masks [3];
        logic [1:0]  hlths [3];
        int          alus  [3];
        logic [4:0]  pmask;
        logic [1:0]  phlth;

        all4 = {5{3'd4}};
        // Vote value 1 must count as an error, 2 as agreement.
        err3 = mk_votes(5'b00100, 3'd1, 3'd2);
        err2 = mk_votes(5'b00010, 3'd1, 3'd2);
        err1 = mk_votes(5'b00001, 3'd0, 3'd4);

        // ALU3 errs 3x, agrees once, errs 3x; then ALU2 persistent failure.
        tbl.push_back(mk(1, err3, 1, 0, 3'd2, 1, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err3, 1, 0, 3'd2, 2, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err3, 1, 0, 3'd2, 3, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, all4, 1, 0, 3'd2, 3, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err3, 3, 0, 3'd2, 4, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err3, 5, 0, 3'd2, 5, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err3, 1, 0, 3'd2, 6, 5'h0, 2'd0, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd6, 17, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err2, 2, 0, 3'd1, 1, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err2, 2, 0, 3'd1, 2, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err2, 2, 0, 3'd1, 3, 5'h0, 2'd0, 0));
        tbl.push_back(mk(1, err2, 2, 0, 3'd1, 4, 5'h2, 2'd1, 1));
        tbl.push_back(mk(0, '0,   0, 0, 3'd7, 32'h102, 5'h2, 2'd1, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd2, 6, 5'h2, 2'd1, 0));
        // Invalid cycle with erring, no-majority inputs changes nothing.
        tbl.push_back(mk(0, mk_votes(5'h1f, 3'd0, 3'd0), 0, 0, 3'd6, 21, 5'h2, 2'd1, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd5, 0, 5'h2, 2'd1, 0));
        // Clear wins over a simultaneous erring sample.
        tbl.push_back(mk(1, err1, 1, 1, 3'd0, 0, 5'h0, 2'd0, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd6, 0, 5'h0, 2'd0, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd1, 0, 5'h0, 2'd0, 0));
        tbl.push_back(mk(0, '0,   0, 0, 3'd7, 0, 5'h0, 2'd0, 0));

        reset_n = 1'b0; ex_valid = 0; vote_count = '0; maj = '0; clear = 0; rd_sel = 3'd6;
        ex_valid2 = 0; vote_count2 = '0; maj2 = '0; clear2 = 0; rd_sel2 = '0;
        #12;
        check("reset.mask", 32'(fail_mask), 32'h0);
        check("reset.health", 32'(health), 32'h0);
        check("reset.irq", 32'(irq), 32'h0);
        check("reset.total", rd_data, 32'h0);
        #10;
        reset_n = 1'b1;

        // Clean traffic: only total counts.
        for (int k = 0; k < 10; k++) step(mk(1, all4, 1, 0, 3'd6, 32'(k + 1), 0, 0, 0));
        idle(3'd3, 0, 5'h0, 2'd0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // ALU1, ALU4, ALU5 fail in turn.
        alus[0] = 0; alus[1] = 3; alus[2] = 4;
        masks[0] = 5'h01; masks[1] = 5'h09; masks[2] = 5'h19;
        hlths[0] = 2'd1;  hlths[1] = 2'd1;  hlths[2] = 2'd2;
        pmask = 5'h0; phlth = 2'd0;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) begin
                step(mk(1, mk_votes(5'(1 << alus[j]), 3'd0, 3'd4), 3'(alus[j] + 1), 0,
                        3'(alus[j]), 32'(c + 1),
                        (c == 3) ? masks[j] : pmask, (c == 3) ? hlths[j] : phlth, c == 3));
            end
            pmask = masks[j];
            phlth = hlths[j];
            idle(3'd7, {22'b0, phlth, 3'b0, pmask}, pmask, phlth);
        end
        idle(3'd7, 32'h0000_0219, 5'h19, 2'd2);
        idle(3'd6, 12, 5'h19, 2'd2);

        // No-majority handling, including statuses 6 and 7.
        step(mk(0, '0, 0, 1, 3'd6, 0, 5'h0, 2'd0, 0));
        step(mk(1, all4, 0, 0, 3'd5, 1, 5'h0, 2'd2, 1));
        step(mk(1, mk_votes(5'h1f, 3'd0, 3'd0), 0, 0, 3'd5, 2, 5'h0, 2'd2, 0));
        step(mk(1, err1, 6, 0, 3'd5, 3, 5'h0, 2'd2, 0));
        step(mk(1, err1, 7, 0, 3'd5, 4, 5'h0, 2'd2, 0));
        idle(3'd0, 0, 5'h0, 2'd2);
        idle(3'd6, 4, 5'h0, 2'd2);
        step(mk(1, all4, 0, 1, 3'd5, 0, 5'h0, 2'd0, 0));
        idle(3'd7, 0, 5'h0, 2'd0);

        // Three ALUs fail on the same sample: one pulse, straight to CRITICAL.
        for (int c = 0; c < 4; c++) begin
            step(mk(1, mk_votes(5'b00111, 3'd1, 3'd3), 4, 0, 3'd2, 32'(c + 1),
                    (c == 3) ? 5'h07 : 5'h0, (c == 3) ? 2'd2 : 2'd0, c == 3));
        end
        idle(3'd7, 32'h0000_0207, 5'h07, 2'd2);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #3;
        check("drain", 32'(pend.size()), 32'h0);
        reset_n = 1'b0;
        #1;
        check("areset.mask", 32'(fail_mask), 32'h0);
        check("areset.health", 32'(health), 32'h0);
        rd_sel = 3'd2;
        #1;
        check("areset.fault2", rd_data, 32'h0);
        #3;
        reset_n = 1'b1;

        // Narrow instance: CNT_W=3, PERSIST_TH=2 saturation.
        @(posedge clk);
        #2;
        ex_valid2 = 1; vote_count2 = mk_votes(5'b00001, 3'd0, 3'd4); maj2 = 3'd2;
        repeat (10) @(posedge clk);
        #2;
        ex_valid2 = 0;
        rd_sel2 = 3'd0; #1; check("sat.fault0", rd_data2, 32'd7);
        rd_sel2 = 3'd6; #1; check("sat.total", rd_data2, 32'd7);
        check("sat.mask", 32'(fail_mask2), 32'h01);
        check("sat.health", 32'(health2), 32'd1);
        @(posedge clk);
        #2;
        ex_valid2 = 1; maj2 = 3'd0;
        repeat (10) @(posedge clk);
        #2;
        ex_valid2 = 0;
        rd_sel2 = 3'd5; #1; check("sat.nomaj", rd_data2, 32'd7);
        rd_sel2 = 3'd0; #1; check("sat.fault0_hold", rd_data2, 32'd7);
        check("sat.health_crit", 32'(health2), 32'd2);
        check("sat.irq_quiet", 32'(irq2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
